// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: line-state encoding common to the tx and rx controllers,
// parity modes and the default oversampling ratio.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int DEFAULT_SAMPLES = 8;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side write port of the UART transmitter: byte, write strobe and buffer status.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] dataIn;
  logic                 writeEn;
  logic                 bufferFull;
  logic                 overrun;

  modport master (output dataIn, output writeEn, input bufferFull, input overrun);
  modport slave  (input dataIn, input writeEn, output bufferFull, output overrun);
endinterface

// File: rtl/uart_tx_shifter.sv
// Frame data path: LSB-first shift register, data-bit counter and running parity,
// stepped by load/shift strobes from the transmit FSM.
module uart_tx_shifter #(
  parameter int DATA_BITS = 8
) (
  input  logic                 sampleClk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_shift,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_bit0,
  output logic                 o_bit1,
  output logic                 o_lastBit,
  output logic                 o_parity
);
  localparam int BW = $clog2(DATA_BITS);

  logic [DATA_BITS-1:0] r_shift;
  logic [BW-1:0]        r_bitCnt;
  logic                 r_par;

  always_ff @(posedge sampleClk) begin
    if (i_load)
      r_shift <= i_data;
    else if (i_shift)
      r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
  end

  // Bit counter saturates on the last data bit instead of wrapping.
  always_ff @(posedge sampleClk or posedge rst) begin
    if (rst) begin
      r_bitCnt <= '0;
      r_par    <= 1'b0;
    end else if (i_load) begin
      r_bitCnt <= '0;
      r_par    <= 1'b0;
    end else if (i_shift) begin
      if (!o_lastBit)
        r_bitCnt <= r_bitCnt + BW'(1);
      r_par <= r_par ^ r_shift[0];
    end
  end

  assign o_bit0    = r_shift[0];
  assign o_bit1    = r_shift[1];
  assign o_lastBit = (r_bitCnt == BW'(DATA_BITS - 1));
  // Parity over every bit shifted so far plus the one currently on the line.
  assign o_parity  = r_par ^ r_shift[0];

endmodule

// File: rtl/uart_tx.sv
// UART transmit controller: one-entry holding buffer feeding a start/data/parity/stop
// serialiser; every bit lasts SAMPLES clocks and frames run back-to-back.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int SAMPLES   = DEFAULT_SAMPLES,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic      sampleClk,
  input  logic      rst,
  uart_tx_if.slave  host,
  output logic      busy,
  output logic      sent,
  output logic      serialOut
);
  localparam int   CW      = $clog2(SAMPLES);
  localparam int   SW      = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
  localparam logic PAR_INV = (PARITY == PAR_ODD);

  uart_state_e          r_state;
  logic [CW-1:0]        r_cnt;
  logic [SW-1:0]        r_stopCnt;
  logic [DATA_BITS-1:0] r_buf;
  logic                 r_bufFull;
  logic                 r_overrun;

  logic w_bitEnd, w_frameEnd, w_xfer, w_accept, w_shift;
  logic w_bit0, w_bit1, w_lastBit, w_parity;

  assign w_bitEnd   = (r_cnt == CW'(SAMPLES - 1));
  assign w_frameEnd = (r_state == ST_STOP) && w_bitEnd && (r_stopCnt == SW'(STOP_BITS - 1));
  assign w_xfer     = r_bufFull && ((r_state == ST_IDLE) || w_frameEnd);
  // A write is taken whenever the buffer is free or being emptied this very cycle.
  assign w_accept   = host.writeEn && (!r_bufFull || w_xfer);
  assign w_shift    = (r_state == ST_DATA) && w_bitEnd;

  uart_tx_shifter #(.DATA_BITS(DATA_BITS)) u_shifter (
    .sampleClk (sampleClk),
    .rst       (rst),
    .i_load    (w_xfer),
    .i_shift   (w_shift),
    .i_data    (r_buf),
    .o_bit0    (w_bit0),
    .o_bit1    (w_bit1),
    .o_lastBit (w_lastBit),
    .o_parity  (w_parity)
  );

  always_ff @(posedge sampleClk) begin
    if (w_accept)
      r_buf <= host.dataIn;
  end

  always_ff @(posedge sampleClk or posedge rst) begin
    if (rst) begin
      r_bufFull <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept)
        r_bufFull <= 1'b1;
      else if (w_xfer)
        r_bufFull <= 1'b0;
      r_overrun <= host.writeEn && r_bufFull && !w_xfer;
    end
  end

  assign host.bufferFull = r_bufFull;
  assign host.overrun    = r_overrun;

  // serialOut is registered: each transition loads the level of the bit about to start.
  always_ff @(posedge sampleClk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_stopCnt <= '0;
      serialOut <= 1'b1;
      busy      <= 1'b0;
      sent      <= 1'b0;
    end else begin
      sent <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (r_bufFull) begin
            r_state   <= ST_START;
            serialOut <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_START: begin
          if (w_bitEnd) begin
            r_cnt     <= '0;
            r_state   <= ST_DATA;
            serialOut <= w_bit0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (w_bitEnd) begin
            r_cnt <= '0;
            if (!w_lastBit) begin
              serialOut <= w_bit1;
            end else if (PARITY != PAR_NONE) begin
              r_state   <= ST_PARITY;
              serialOut <= w_parity ^ PAR_INV;
            end else begin
              r_state   <= ST_STOP;
              r_stopCnt <= '0;
              serialOut <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_PARITY: begin
          if (w_bitEnd) begin
            r_cnt     <= '0;
            r_state   <= ST_STOP;
            r_stopCnt <= '0;
            serialOut <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (w_frameEnd) begin
            r_cnt     <= '0;
            r_stopCnt <= '0;
            sent      <= 1'b1;
            if (r_bufFull) begin
              r_state   <= ST_START;
              serialOut <= 1'b0;
            end else begin
              r_state   <= ST_IDLE;
              serialOut <= 1'b1;
              busy      <= 1'b0;
            end
          end else if (w_bitEnd) begin
            r_cnt     <= '0;
            r_stopCnt <= r_stopCnt + SW'(1);
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          serialOut <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: scoreboarded line monitor on a default instance, plus directed
// frames on an odd-parity, two-stop-bit instance.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_if #(.DATA_BITS(8)) if0 ();
  uart_tx_if #(.DATA_BITS(8)) if1 ();
  logic busy0, sent0, so0, busy1, sent1, so1;

  uart_tx #(.DATA_BITS(8), .SAMPLES(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .sampleClk(clk), .rst(rst), .host(if0), .busy(busy0), .sent(sent0), .serialOut(so0));

  uart_tx #(.DATA_BITS(8), .SAMPLES(8), .PARITY(2), .STOP_BITS(2)) dut1 (
    .sampleClk(clk), .rst(rst), .host(if1), .busy(busy1), .sent(sent1), .serialOut(so1));

  int n_pass = 0;
  int n_total = 0;

  task automatic fail(input string nm, input int act, input int exp);
    n_total++;
    $display("FAIL %s: actual %0d required %0d", nm, act, exp);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    if (act == exp) begin
      n_total++;
      n_pass++;
    end else begin
      fail(nm, act, exp);
    end
  endtask

  // Expected line level c cycles into a frame of 8 data bits at 8 clocks per bit.
  function automatic logic lvl(input logic [7:0] b, input int c, input int par);
    int idx;
    idx = c / 8;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (par != 0 && idx == 9) return (^b) ^ (par == 2);
    return 1'b1;
  endfunction

  localparam int FL0 = 80;

  // Scoreboard for instance 0: bytes expected on the line, in order.
  logic [7:0] sb[$];
  int         starts[$];
  logic [7:0] cur;
  bit         in_frame = 0;
  bit         sent_due = 0;
  int         pos, nbad, firstbad, ovr_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_frame = 0;
      sent_due = 0;
    end else begin
      if (sent_due) begin
        chk("sent_pulse", int'(sent0), 1);
        sent_due = 0;
      end else if (sent0) begin
        fail("sent_spurious", 1, 0);
      end
      if (if0.overrun) ovr_cnt++;
      if (!in_frame && so0 == 1'b0) begin
        if (sb.size() == 0) begin
          fail("unexpected_frame_queue", 0, 1);
          cur = 8'h00;
        end else begin
          cur = sb.pop_front();
        end
        in_frame = 1;
        pos      = 0;
        nbad     = 0;
        firstbad = -1;
        starts.push_back(cyc);
      end
      if (in_frame) begin
        if (so0 !== lvl(cur, pos, 0) || busy0 !== 1'b1) begin
          nbad++;
          if (firstbad < 0) firstbad = pos;
        end
        pos++;
        if (pos == FL0) begin
          if (nbad != 0) $display("frame %02h first bad cycle %0d", cur, firstbad);
          chk($sformatf("frame_%02h_badcycles", cur), nbad, 0);
          in_frame = 0;
          sent_due = 1;
        end
      end
    end
  end

  task automatic wr0(input logic [7:0] b, input bit accepted);
    if0.dataIn  = b;
    if0.writeEn = 1'b1;
    if (accepted) sb.push_back(b);
    @(negedge clk);
    if0.writeEn = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit done = 0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !in_frame && !sent_due) done = 1;
    end
    if (!done) fail({nm, "_timeout"}, 0, 1);
  endtask

  task automatic wait_bf0(input string nm);
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      #1;
      if (if0.bufferFull == 1'b0) done = 1;
    end
    if (!done) fail({nm, "_bf_timeout"}, 0, 1);
  endtask

  task automatic frame1(input logic [7:0] b, input bit pchk);
    int bad = 0;
    @(negedge clk);
    if1.dataIn  = b;
    if1.writeEn = 1'b1;
    @(negedge clk);
    if1.writeEn = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 96; c++) begin
      if (so1 !== lvl(b, c, 2) || sent1 !== 1'b0) bad++;
      if (pchk && c == 76) chk("p2_parity_bit_07", int'(so1), 0);
      @(negedge clk);
    end
    chk($sformatf("p2_frame_%02h_badcycles", b), bad, 0);
    chk("p2_sent_at_96", int'(sent1), 1);
    chk("p2_line_idle_after", int'(so1), 1);
    chk("p2_busy_after", int'(busy1), 0);
  endtask

  initial begin
    int ov0;
    logic [7:0] rb;
    rst = 1'b1;
    if0.dataIn = '0; if0.writeEn = 1'b0;
    if1.dataIn = '0; if1.writeEn = 1'b0;
    #3;
    chk("rst_serialOut", int'(so0), 1);
    chk("rst_bufferFull", int'(if0.bufferFull), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_sent", int'(sent0), 0);
    chk("rst_overrun", int'(if0.overrun), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame 0xA5 from idle, with latency checks.
    wr0(8'hA5, 1);
    chk("a5_bufferFull_after_n", int'(if0.bufferFull), 1);
    chk("a5_line_high_after_n", int'(so0), 1);
    @(negedge clk);
    chk("a5_start_after_n1", int'(so0), 0);
    chk("a5_busy_after_n1", int'(busy0), 1);
    chk("a5_bufferFull_drop", int'(if0.bufferFull), 0);
    wait_idle("a5");

    // Streaming: second byte written while the first shifts.
    starts.delete();
    ov0 = ovr_cnt;
    @(negedge clk);
    wr0(8'h3C, 1);
    repeat (20) @(negedge clk);
    wr0(8'h81, 1);
    wait_idle("stream");
    if (starts.size() >= 2) chk("stream_gap", starts[1] - starts[0], FL0);
    else fail("stream_frames", starts.size(), 2);
    chk("stream_no_overrun", ovr_cnt - ov0, 0);

    // Overrun: third write while buffer is full is dropped.
    starts.delete();
    @(negedge clk);
    wr0(8'h11, 1);
    @(negedge clk);
    wr0(8'h22, 1);
    chk("ovr_bufferFull", int'(if0.bufferFull), 1);
    wr0(8'h33, 0);
    chk("ovr_pulse", int'(if0.overrun), 1);
    @(negedge clk);
    chk("ovr_pulse_end", int'(if0.overrun), 0);
    wait_idle("ovr");

    // Write on the same edge as the idle-to-start transfer.
    starts.delete();
    ov0 = ovr_cnt;
    @(negedge clk);
    wr0(8'h5A, 1);
    wr0(8'hC3, 1);
    chk("coin_bufferFull", int'(if0.bufferFull), 1);
    chk("coin_start", int'(so0), 0);
    wait_idle("coin");
    if (starts.size() >= 2) chk("coin_gap", starts[1] - starts[0], FL0);
    else fail("coin_frames", starts.size(), 2);
    chk("coin_no_overrun", ovr_cnt - ov0, 0);

    // Random stream with random host pauses.
    for (int k = 0; k < 16; k++) begin
      wait_bf0("rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rb = 8'($urandom_range(0, 255));
      wr0(rb, 1);
    end
    wait_idle("rand");

    // Asynchronous reset in the middle of a data bit.
    @(negedge clk);
    wr0(8'h96, 1);
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_serialOut", int'(so0), 1);
    chk("midrst_bufferFull", int'(if0.bufferFull), 0);
    chk("midrst_busy", int'(busy0), 0);
    @(negedge clk);
    chk("midrst_no_sent", int'(sent0), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wr0(8'hE1, 1);
    wait_idle("postrst");
    chk("sb_drained", sb.size(), 0);

    // Odd parity, two stop bits.
    frame1(8'h07, 1);
    for (int k = 0; k < 3; k++) frame1(8'($urandom_range(0, 255)), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
